// File: rtl/ppu_sprite_pixel_fetch_pkg.sv
// Shared types and field positions for the sprite pixel fetch stage:
// FSM states, OAM attribute bit positions and CHR address layout.
package ppu_sprite_pixel_fetch_pkg;

  localparam int CHR_AW = 14;

  localparam int ATTR_VFLIP  = 7;
  localparam int ATTR_HFLIP  = 6;
  localparam int ATTR_BEHIND = 5;
  localparam int ATTR_PAL_LO = 0;

  localparam int ADDR_TABLE_BIT = 12;
  localparam int ADDR_TILE_LSB  = 4;
  localparam int ADDR_PLANE_BIT = 3;
  localparam int ADDR_FINEY_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0L,
    S_F0H,
    S_F1L,
    S_F1H,
    S_CAP,
    S_MERGE,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       onTile;
    logic       is0;
    logic [7:0] tileNum;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] attr;
  } slot_t;

  // Row within the 8-line tile; only the low three bits of the difference matter.
  function automatic logic [2:0] fineY(input logic [2:0] currRow,
                                       input logic [2:0] spriteRow,
                                       input logic       vflip);
    logic [2:0] fy;
    fy = currRow - spriteRow;
    return vflip ? (3'd7 - fy) : fy;
  endfunction

  function automatic logic [CHR_AW-1:0] chrAddr(input logic       tableSel,
                                                input logic [7:0] tileNum,
                                                input logic       plane,
                                                input logic [2:0] fy);
    logic [CHR_AW-1:0] a;
    a = '0;
    a[ADDR_TABLE_BIT]         = tableSel;
    a[ADDR_TILE_LSB +: 8]     = tileNum;
    a[ADDR_PLANE_BIT]         = plane;
    a[ADDR_FINEY_LSB +: 3]    = fy;
    return a;
  endfunction

endpackage

// File: rtl/ppu_sprite_pixel_fetch_if.sv
// Start/done handshake, CHR read bus and merged pixel outputs of the sprite fetch stage.
interface ppu_sprite_pixel_fetch_if;
  import ppu_sprite_pixel_fetch_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [CHR_AW-1:0] chr_addr;
  logic              chr_rd;
  logic [7:0]        chr_data;
  logic [15:0]       pix_pattern;
  logic [15:0]       pix_palette;
  logic [7:0]        pix_behind;
  logic [7:0]        pix_is_0;

  modport master (
    input  start, chr_data,
    output busy, done, chr_addr, chr_rd,
           pix_pattern, pix_palette, pix_behind, pix_is_0
  );

  modport slave (
    output start, chr_data,
    input  busy, done, chr_addr, chr_rd,
           pix_pattern, pix_palette, pix_behind, pix_is_0
  );

endinterface

// File: rtl/ppu_sprite_pixel_fetch_row_align.sv
// Places one sprite's 8-pixel pattern row onto the current tile, honouring
// horizontal flip; pixels outside the sprite come out transparent.
module ppu_sprite_pixel_fetch_row_align (
  input  logic [7:0]  i_lo,
  input  logic [7:0]  i_hi,
  input  logic [7:0]  i_col,
  input  logic        i_hflip,
  input  logic [8:0]  i_tile_col,
  output logic [15:0] o_pattern,
  output logic [7:0]  o_covered
);

  for (genvar i = 0; i < 8; i++) begin : g_pix
    logic [9:0] w_d;
    logic [2:0] w_k;
    logic       w_in;

    // Ten bits keep x >= 256 from wrapping back onto a sprite at low columns.
    assign w_d  = {i_tile_col[8], i_tile_col} + 10'(i) - {2'b00, i_col};
    assign w_in = (w_d[9:3] == 7'd0);
    assign w_k  = i_hflip ? w_d[2:0] : (3'd7 - w_d[2:0]);

    assign o_pattern[2*i +: 2] = w_in ? {i_hi[w_k], i_lo[w_k]} : 2'b00;
    assign o_covered[i]        = w_in;
  end

endmodule

// File: rtl/ppu_sprite_pixel_fetch.sv
// Sprite pattern fetch for one 8-pixel tile: reads both slots' plane bytes,
// aligns them to the tile and merges by slot priority into registered pixels.
module ppu_sprite_pixel_fetch
  import ppu_sprite_pixel_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ppu_sprite_pixel_fetch_if.master bus,
  input  logic       i_sprite_table_sel,
  input  logic [8:0] i_curr_row,
  input  logic [8:0] i_tile_col,
  input  logic       i_s0_on_tile,
  input  logic       i_s0_is_0,
  input  logic [7:0] i_s0_tile_num,
  input  logic [7:0] i_s0_row,
  input  logic [7:0] i_s0_col,
  input  logic [7:0] i_s0_attr,
  input  logic       i_s1_on_tile,
  input  logic       i_s1_is_0,
  input  logic [7:0] i_s1_tile_num,
  input  logic [7:0] i_s1_row,
  input  logic [7:0] i_s1_col,
  input  logic [7:0] i_s1_attr
);

  state_t            r_state, w_nextState;
  slot_t             r_slot0, r_slot1;
  logic              r_tableSel;
  logic [8:0]        r_currRow, r_tileCol;
  logic [7:0]        r_lo0, r_hi0, r_lo1, r_hi1;
  logic [15:0]       r_pixPattern, r_pixPalette;
  logic [7:0]        r_pixBehind, r_pixIs0;
  logic [2:0]        w_fineY0, w_fineY1;
  logic [CHR_AW-1:0] w_chrAddr;
  logic              w_chrRd;
  logic [15:0]       w_pat0, w_pat1;
  logic [7:0]        w_cov0, w_cov1;
  logic [15:0]       w_mergePattern, w_mergePalette;
  logic [7:0]        w_mergeBehind, w_mergeIs0;
  logic              w_unused;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  // Fixed-length sequence: absent slots still spend their fetch cycles.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_nextState = S_F0L;
      S_F0L:   w_nextState = S_F0H;
      S_F0H:   w_nextState = S_F1L;
      S_F1L:   w_nextState = S_F1H;
      S_F1H:   w_nextState = S_CAP;
      S_CAP:   w_nextState = S_MERGE;
      S_MERGE: w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot0    <= '0;
      r_slot1    <= '0;
      r_tableSel <= 1'b0;
      r_currRow  <= '0;
      r_tileCol  <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_slot0.onTile  <= i_s0_on_tile;
      r_slot0.is0     <= i_s0_is_0;
      r_slot0.tileNum <= i_s0_tile_num;
      r_slot0.row     <= i_s0_row;
      r_slot0.col     <= i_s0_col;
      r_slot0.attr    <= i_s0_attr;
      r_slot1.onTile  <= i_s1_on_tile;
      r_slot1.is0     <= i_s1_is_0;
      r_slot1.tileNum <= i_s1_tile_num;
      r_slot1.row     <= i_s1_row;
      r_slot1.col     <= i_s1_col;
      r_slot1.attr    <= i_s1_attr;
      r_tableSel      <= i_sprite_table_sel;
      r_currRow       <= i_curr_row;
      r_tileCol       <= i_tile_col;
    end
  end

  assign w_fineY0 = fineY(r_currRow[2:0], r_slot0.row[2:0], r_slot0.attr[ATTR_VFLIP]);
  assign w_fineY1 = fineY(r_currRow[2:0], r_slot1.row[2:0], r_slot1.attr[ATTR_VFLIP]);

  always_comb begin
    w_chrAddr = '0;
    w_chrRd   = 1'b0;
    case (r_state)
      S_F0L: if (r_slot0.onTile) begin
        w_chrRd   = 1'b1;
        w_chrAddr = chrAddr(r_tableSel, r_slot0.tileNum, 1'b0, w_fineY0);
      end
      S_F0H: if (r_slot0.onTile) begin
        w_chrRd   = 1'b1;
        w_chrAddr = chrAddr(r_tableSel, r_slot0.tileNum, 1'b1, w_fineY0);
      end
      S_F1L: if (r_slot1.onTile) begin
        w_chrRd   = 1'b1;
        w_chrAddr = chrAddr(r_tableSel, r_slot1.tileNum, 1'b0, w_fineY1);
      end
      S_F1H: if (r_slot1.onTile) begin
        w_chrRd   = 1'b1;
        w_chrAddr = chrAddr(r_tableSel, r_slot1.tileNum, 1'b1, w_fineY1);
      end
      default: ;
    endcase
  end

  // Read data lands one cycle after its request, so each state captures its predecessor's byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lo0 <= '0;
      r_hi0 <= '0;
      r_lo1 <= '0;
      r_hi1 <= '0;
    end else begin
      case (r_state)
        S_F0H:   r_lo0 <= r_slot0.onTile ? bus.chr_data : 8'h00;
        S_F1L:   r_hi0 <= r_slot0.onTile ? bus.chr_data : 8'h00;
        S_F1H:   r_lo1 <= r_slot1.onTile ? bus.chr_data : 8'h00;
        S_CAP:   r_hi1 <= r_slot1.onTile ? bus.chr_data : 8'h00;
        default: ;
      endcase
    end
  end

  ppu_sprite_pixel_fetch_row_align u_align0 (
    .i_lo       (r_lo0),
    .i_hi       (r_hi0),
    .i_col      (r_slot0.col),
    .i_hflip    (r_slot0.attr[ATTR_HFLIP]),
    .i_tile_col (r_tileCol),
    .o_pattern  (w_pat0),
    .o_covered  (w_cov0)
  );

  ppu_sprite_pixel_fetch_row_align u_align1 (
    .i_lo       (r_lo1),
    .i_hi       (r_hi1),
    .i_col      (r_slot1.col),
    .i_hflip    (r_slot1.attr[ATTR_HFLIP]),
    .i_tile_col (r_tileCol),
    .o_pattern  (w_pat1),
    .o_covered  (w_cov1)
  );

  for (genvar i = 0; i < 8; i++) begin : g_merge
    logic w_op0, w_op1, w_win0, w_win1;

    assign w_op0  = w_cov0[i] && (w_pat0[2*i +: 2] != 2'b00);
    assign w_op1  = w_cov1[i] && (w_pat1[2*i +: 2] != 2'b00);
    assign w_win0 = w_op0;
    assign w_win1 = w_op1 && !w_op0;

    assign w_mergePattern[2*i +: 2] = w_win0 ? w_pat0[2*i +: 2] :
                                      w_win1 ? w_pat1[2*i +: 2] : 2'b00;
    assign w_mergePalette[2*i +: 2] = w_win0 ? r_slot0.attr[ATTR_PAL_LO +: 2] :
                                      w_win1 ? r_slot1.attr[ATTR_PAL_LO +: 2] : 2'b00;
    assign w_mergeBehind[i] = w_win0 ? r_slot0.attr[ATTR_BEHIND] :
                              w_win1 ? r_slot1.attr[ATTR_BEHIND] : 1'b0;
    // Sprite-0 hit cares about opacity, not about which slot is shown.
    assign w_mergeIs0[i] = (r_slot0.is0 && w_op0) || (r_slot1.is0 && w_op1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pixPattern <= '0;
      r_pixPalette <= '0;
      r_pixBehind  <= '0;
      r_pixIs0     <= '0;
    end else if (r_state == S_MERGE) begin
      r_pixPattern <= w_mergePattern;
      r_pixPalette <= w_mergePalette;
      r_pixBehind  <= w_mergeBehind;
      r_pixIs0     <= w_mergeIs0;
    end
  end

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.chr_addr    = w_chrAddr;
  assign bus.chr_rd      = w_chrRd;
  assign bus.pix_pattern = r_pixPattern;
  assign bus.pix_palette = r_pixPalette;
  assign bus.pix_behind  = r_pixBehind;
  assign bus.pix_is_0    = r_pixIs0;

  assign w_unused = ^{r_currRow[8:3], r_slot0.row[7:3], r_slot1.row[7:3],
                      r_slot0.attr[4:2], r_slot1.attr[4:2]};

endmodule

// File: doc/ppu_sprite_pixel_fetch.md
# ppu_sprite_pixel_fetch

Per-tile sprite pattern fetch and pixel merge stage, directly downstream of the sprite load FSM. For each 8-pixel tile it reads the two selected sprites' pattern-plane bytes from CHR memory and applies flip and horizontal alignment. It merges the two sprites by slot priority and presents 8 registered sprite pixels, with palette, priority and sprite-0 flags, to the pixel mux.

## Interface
- CHR_AW, 14, CHR address width; bit 13 always driven 0.
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start  in  1  begin one tile fetch; accepted only in IDLE
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse; pixel outputs valid from this cycle
- sprite_table_sel  in  1  PPUCTRL sprite pattern table select (address bit 12)
- curr_row  in  9  current scanline
- tile_col  in  9  screen x of pixel 0 of this tile, two's complement (may be negative)
- sN_on_tile, sN_is_0  in  1 each  upstream slot N (N = 0, 1) valid / is OAM sprite 0
- sN_tile_num, sN_row, sN_col, sN_attr  in  8 each  upstream slot N attributes
- chr_addr  out  CHR_AW  pattern read address
- chr_rd  out  1  read strobe
- chr_data  in  8  read data, valid the cycle after chr_addr/chr_rd
- pix_pattern  out  16  2-bit pattern per pixel, pixel i at [2i+:2]; 0 = transparent
- pix_palette  out  16  2-bit sprite palette per pixel
- pix_behind  out  8  attr[5] of the winning sprite per pixel
- pix_is_0  out  8  opaque pixel from an is_0 slot, independent of which slot wins

## Operation
- **IDLE, start = 1:** snapshot all sN_* inputs, curr_row, tile_col and sprite_table_sel into internal registers, then go to F0L. In-flight inputs are ignored after the snapshot.
- **State sequence:** F0L → F0H → F1L → F1H → CAP → MERGE → DONE → IDLE. The sequence is fixed, so latency is the same whether or not each sprite is present.
- **Fetch addresses:** fine_y = (curr_row[7:0] − sN_row)[2:0]. If attr[7] is set, fine_y = 7 − fine_y. chr_addr = {1'b0, table_sel, tile_num, plane, fine_y}.
  - F0L: plane 0 of slot 0. F0H: plane 1 of slot 0. F1L: plane 0 of slot 1. F1H: plane 1 of slot 1.
  - chr_rd is high only when that slot's sN_on_tile is set. Otherwise chr_addr = 0 and the captured plane is forced to 0x00.
- **Capture:** each state captures chr_data requested by the previous state: F0H←lo0, F1L←hi0, F1H←lo1, CAP←hi1.
- **Alignment, per slot and pixel i = 0..7:**
  - d = tile_col + i − {0, sN_col}, computed signed at 10 bits.
  - If 0 ≤ d ≤ 7: bit index k = 7 − d normally, or k = d when attr[6] is set. pattern = {hi[k], lo[k]}.
  - Otherwise pattern = 0.
- **Merge, per pixel:** slot 0 wins if its pattern != 0; else slot 1 if its pattern != 0; else output 0. palette and behind come from the winning slot's attr[1:0] and attr[5]. If no slot wins, palette = 0 and behind = 0.
- **MERGE:** registers all pix_* outputs.
- **DONE:** pulses done. Outputs hold until the next MERGE.

## Timing
- start accepted at cycle 0. chr reads are driven on cycles 1–4. Outputs update at the cycle-6 edge. done is high on cycle 7. busy is high on cycles 1–7.
- A new start is accepted on cycle 8 at the earliest. start asserted while busy is dropped, not queued.
- **Reset (rst low at a clock edge):**
  - state = IDLE.
  - All outputs = 0, including chr_addr, chr_rd, done and every pix_* bus.
  - Snapshot registers are cleared.
  - Reset mid-fetch aborts without a done pulse.
- Both slots absent: no chr_rd is issued, all pix_* are 0 and done still pulses on cycle 7.
- tile_col of −8 or below, or sprite_col + 8 ≤ tile_col, gives a fully transparent slot.
- d is computed at 10 bits, so x ≥ 256 does not wrap onto the sprite.

## Structure
- **ppu_pkg:** state enum, attr bit positions (VFLIP = 7, HFLIP = 6, BEHIND = 5, PAL = 1:0), and chr address field offsets.
- **ppu_sprite_row_align:** sub-module instantiated once per slot. Purely combinational: takes {lo, hi, col, attr, tile_col} and returns 16-bit pattern, 8-bit covered mask.
- Top-level: FSM, capture registers, merge logic and output registers.

## Test plan
- **Basic fetch:** slot0 tile 0x12, row 0x20, col 0x40, attr 0x01; curr_row 0x23, tile_col 0x40, table 0; chr returns lo = 0xF0, hi = 0x0F.
  - chr_addr 0x0123 then 0x012B.
  - pix_pattern = 0xAA55, i.e. pixels 0–3 = 1 and pixels 4–7 = 2.
  - Every pixel has palette 1; done on cycle 7.
- **Vertical flip:** same setup with attr 0x80 → chr_addr 0x0124 then 0x012C.
- **Horizontal flip and offset:** col 0x44, attr 0x40, lo = 0x01, hi = 0x00 → pixel 4 pattern = 1, all other pixels 0.
- **Priority:** both slots at col 0x40; slot0 lo = 0x0F, attr 0x03; slot1 lo = 0xFF, attr 0x02.
  - Pixels 0–3: palette 2 (slot 1).
  - Pixels 4–7: palette 3 (slot 0).
  - With s1_is_0 = 1, pix_is_0 = 0xFF.
- **Negative column:** tile_col 0x1FC, slot0 col 0x00, lo = 0xFF → pixels 0–3 pattern 0, pixels 4–7 pattern 1.
- **Reset and dropped start:** rst low on cycle 3 → no done, all outputs 0; a following start completes normally. A start pulsed while busy is ignored.
